// File: rtl/mips_pkg.sv
// mips_pkg: constants and types shared by the MIPS pipeline stages.
//   ALUop class codes and R-type Function codes. ID-stage decode uses the same
//   constants, so the encodings live here and nowhere else.
//   ex_state_t: execute-stage multiplier FSM states.
package mips_pkg;

    localparam logic [2:0] ALUOP_ADD   = 3'b000;
    localparam logic [2:0] ALUOP_SUB   = 3'b001;
    localparam logic [2:0] ALUOP_RTYPE = 3'b010;
    localparam logic [2:0] ALUOP_AND   = 3'b011;
    localparam logic [2:0] ALUOP_OR    = 3'b100;
    localparam logic [2:0] ALUOP_SLT   = 3'b101;
    localparam logic [2:0] ALUOP_LUI   = 3'b110;

    localparam logic [5:0] FN_ADD  = 6'b100000;
    localparam logic [5:0] FN_SUB  = 6'b100010;
    localparam logic [5:0] FN_AND  = 6'b100100;
    localparam logic [5:0] FN_OR   = 6'b100101;
    localparam logic [5:0] FN_XOR  = 6'b100110;
    localparam logic [5:0] FN_NOR  = 6'b100111;
    localparam logic [5:0] FN_SLT  = 6'b101010;
    localparam logic [5:0] FN_MULT = 6'b011000;

    typedef enum logic {
        IDLE = 1'b0,
        MUL  = 1'b1
    } ex_state_t;

endpackage

// File: rtl/mult_iter.sv
// mult_iter: iterative shift-add multiplier, one partial product per cycle.
//   Compiled only when EX_MULT_EN is defined.
//   clk, rst     : clock, synchronous active-high reset (discards any product)
//   hold_i       : 1 = freeze every register (cache miss)
//   start_i      : load a_i/b_i and begin; count restarts at 0
//   busy_o       : iteration in progress
//   done_o       : final iteration this cycle; result_o is the finished product
//   result_o     : low WIDTH bits of a_i * b_i (valid when done_o)
`ifdef EX_MULT_EN
module mult_iter #(
    parameter int WIDTH  = 32,
    parameter int CYCLES = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             hold_i,
    input  logic             start_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] result_o
);
    localparam int CW = (CYCLES > 1) ? $clog2(CYCLES) : 1;

    logic [CW-1:0]    cnt_q;
    logic             busy_q;
    logic [WIDTH-1:0] acc_q, mcand_q, mplier_q;
    logic [WIDTH-1:0] acc_d;

    // Partial product for the current multiplier bit; on the last step this
    // sum is the product, so the consumer captures it without an extra cycle.
    assign acc_d    = acc_q + (mplier_q[0] ? mcand_q : '0);
    assign busy_o   = busy_q;
    assign done_o   = busy_q && (cnt_q == CW'(CYCLES - 1));
    assign result_o = acc_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
        end else if (!hold_i) begin
            if (start_i) begin
                cnt_q    <= '0;
                busy_q   <= 1'b1;
                acc_q    <= '0;
                mcand_q  <= a_i;
                mplier_q <= b_i;
            end else if (busy_q) begin
                acc_q    <= acc_d;
                mcand_q  <= mcand_q << 1;
                mplier_q <= mplier_q >> 1;
                cnt_q    <= cnt_q + CW'(1);
                if (done_o) busy_q <= 1'b0;
            end
        end
    end
endmodule
`endif

// File: rtl/ex_stage.sv
// ex_stage: MIPS execute stage. Takes ID/EX fields, computes the ALU result,
// destination register, store data and branch decision, and registers them
// for MEM.
//   clk, rst      : clock, synchronous active-high reset (overrides hit)
//   hit           : 1 = advance, 0 = freeze everything (cache miss)
//   readData1/2, immediate, nextPC, controls, ALUop, RT, RD, Function : ID/EX
//   ALUresult, writeData, writeReg, *_out, zero, branchTaken, branchTarget :
//                   registered EX/MEM outputs
//   stall         : combinational, 1 = ID/EX must hold (multiply in progress)
// Build option: EX_MULT_EN enables the iterative multiplier (Function 011000).
// Without it, mult is an unknown R-type code (result 0) and stall is 0.
module ex_stage
    import mips_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int MUL_CYCLES = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             hit,
    input  logic [WIDTH-1:0] readData1,
    input  logic [WIDTH-1:0] readData2,
    input  logic [WIDTH-1:0] immediate,
    input  logic [WIDTH-1:0] nextPC,
    input  logic             destinationReg,
    input  logic             ALUsrc,
    input  logic             MemToReg,
    input  logic             RegWrite,
    input  logic             MEM_Read,
    input  logic             MEM_Write,
    input  logic             branch,
    input  logic [2:0]       ALUop,
    input  logic [4:0]       RT,
    input  logic [4:0]       RD,
    input  logic [5:0]       Function,
    output logic [WIDTH-1:0] ALUresult,
    output logic [WIDTH-1:0] writeData,
    output logic [4:0]       writeReg,
    output logic             MemToReg_out,
    output logic             RegWrite_out,
    output logic             MEM_Read_out,
    output logic             MEM_Write_out,
    output logic             zero,
    output logic             branchTaken,
    output logic [WIDTH-1:0] branchTarget,
    output logic             stall
);
    logic [WIDTH-1:0] op_b, alu_res, res_d, mul_result;
    logic             slt_bit, mul_done;

    assign op_b    = ALUsrc ? immediate : readData2;
    assign slt_bit = $signed(readData1) < $signed(op_b);

    always_comb begin
        alu_res = '0;
        case (ALUop)
            ALUOP_ADD:   alu_res = readData1 + op_b;
            ALUOP_SUB:   alu_res = readData1 - op_b;
            ALUOP_AND:   alu_res = readData1 & op_b;
            ALUOP_OR:    alu_res = readData1 | op_b;
            ALUOP_SLT:   alu_res = {{(WIDTH-1){1'b0}}, slt_bit};
            ALUOP_LUI:   alu_res = op_b << 16;
            ALUOP_RTYPE: begin
                case (Function)
                    FN_ADD:  alu_res = readData1 + op_b;
                    FN_SUB:  alu_res = readData1 - op_b;
                    FN_AND:  alu_res = readData1 & op_b;
                    FN_OR:   alu_res = readData1 | op_b;
                    FN_XOR:  alu_res = readData1 ^ op_b;
                    FN_NOR:  alu_res = ~(readData1 | op_b);
                    FN_SLT:  alu_res = {{(WIDTH-1){1'b0}}, slt_bit};
                    default: alu_res = '0;
                endcase
            end
            default:     alu_res = '0;
        endcase
    end

`ifdef EX_MULT_EN
    ex_state_t state_q, state_d;
    logic      mult_present, mul_busy;

    assign mult_present = (ALUop == ALUOP_RTYPE) && (Function == FN_MULT);

    always_comb begin
        state_d = state_q;
        if (hit) begin
            case (state_q)
                IDLE:    if (mult_present) state_d = MUL;
                MUL:     if (mul_done) state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    mult_iter #(.WIDTH(WIDTH), .CYCLES(MUL_CYCLES)) u_mult (
        .clk      (clk),
        .rst      (rst),
        .hold_i   (!hit),
        .start_i  ((state_q == IDLE) && mult_present),
        .a_i      (readData1),
        .b_i      (op_b),
        .busy_o   (mul_busy),
        .done_o   (mul_done),
        .result_o (mul_result)
    );

    // The final iteration cycle is not a stall: ID/EX advances on the same
    // edge that captures the product.
    assign stall = !rst && (((state_q == IDLE) && mult_present) ||
                            (mul_busy && !mul_done));
`else
    assign mul_done   = 1'b0;
    assign mul_result = '0;
    assign stall      = 1'b0;
`endif

    assign res_d = mul_done ? mul_result : alu_res;

    always_ff @(posedge clk) begin
        if (rst || (hit && stall)) begin
            // Reset and stall bubbles both clear the whole EX/MEM register.
            ALUresult     <= '0;
            writeData     <= '0;
            writeReg      <= '0;
            MemToReg_out  <= 1'b0;
            RegWrite_out  <= 1'b0;
            MEM_Read_out  <= 1'b0;
            MEM_Write_out <= 1'b0;
            zero          <= 1'b0;
            branchTaken   <= 1'b0;
            branchTarget  <= '0;
        end else if (hit) begin
            ALUresult     <= res_d;
            writeData     <= readData2;
            writeReg      <= destinationReg ? RD : RT;
            MemToReg_out  <= MemToReg;
            RegWrite_out  <= RegWrite;
            MEM_Read_out  <= MEM_Read;
            MEM_Write_out <= MEM_Write;
            zero          <= (res_d == '0);
            branchTaken   <= branch && (readData1 == readData2);
            branchTarget  <= nextPC + (immediate << 2);
        end
    end
endmodule

// File: tb/tb_ex_stage.sv
module tb_ex_stage;
    logic        clk = 1'b0;
    logic        rst, hit;
    logic [31:0] readData1, readData2, immediate, nextPC;
    logic        destinationReg, ALUsrc, MemToReg, RegWrite, MEM_Read, MEM_Write, branch;
    logic [2:0]  ALUop;
    logic [4:0]  RT, RD;
    logic [5:0]  Function;
    logic [31:0] ALUresult, writeData, branchTarget;
    logic [4:0]  writeReg;
    logic        MemToReg_out, RegWrite_out, MEM_Read_out, MEM_Write_out;
    logic        zero, branchTaken, stall;

    int nvec = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    ex_stage #(.WIDTH(32), .MUL_CYCLES(32)) dut (
        .clk(clk), .rst(rst), .hit(hit),
        .readData1(readData1), .readData2(readData2), .immediate(immediate), .nextPC(nextPC),
        .destinationReg(destinationReg), .ALUsrc(ALUsrc), .MemToReg(MemToReg),
        .RegWrite(RegWrite), .MEM_Read(MEM_Read), .MEM_Write(MEM_Write), .branch(branch),
        .ALUop(ALUop), .RT(RT), .RD(RD), .Function(Function),
        .ALUresult(ALUresult), .writeData(writeData), .writeReg(writeReg),
        .MemToReg_out(MemToReg_out), .RegWrite_out(RegWrite_out),
        .MEM_Read_out(MEM_Read_out), .MEM_Write_out(MEM_Write_out),
        .zero(zero), .branchTaken(branchTaken), .branchTarget(branchTarget), .stall(stall)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic nop_inputs();
        readData1 = 0; readData2 = 0; immediate = 0; nextPC = 0;
        destinationReg = 0; ALUsrc = 0; MemToReg = 0; RegWrite = 0;
        MEM_Read = 0; MEM_Write = 0; branch = 0; ALUop = 3'b000;
        RT = 0; RD = 0; Function = 0;
    endtask

    task automatic set_mult(input logic [31:0] a, input logic [31:0] b);
        nop_inputs();
        readData1 = a; readData2 = b; ALUop = 3'b010; Function = 6'b011000;
        RegWrite = 1; destinationReg = 1; RD = 5'd7;
    endtask

    task automatic test_reset();
        rst = 1; hit = 0;
        readData1 = $urandom; readData2 = $urandom; immediate = $urandom; nextPC = $urandom;
        {destinationReg, ALUsrc, MemToReg, RegWrite, MEM_Read, MEM_Write, branch} = 7'($urandom);
        ALUop = 3'($urandom); RT = 5'($urandom); RD = 5'($urandom); Function = 6'($urandom);
        #1;
        nvec++; if (stall !== 1'b0) begin nerr++; $display("FAIL reset_stall got %b want 0", stall); end
        step();
        hit = 1;
        step();
        nvec++;
        if ({ALUresult, writeData, branchTarget} !== 96'd0 || writeReg !== 5'd0) begin
            nerr++; $display("FAIL reset_data got %h %h %h %h want 0", ALUresult, writeData, branchTarget, writeReg);
        end
        nvec++;
        if ({MemToReg_out, RegWrite_out, MEM_Read_out, MEM_Write_out, zero, branchTaken, stall} !== 7'd0) begin
            nerr++; $display("FAIL reset_ctrl got %b want 0000000",
                {MemToReg_out, RegWrite_out, MEM_Read_out, MEM_Write_out, zero, branchTaken, stall});
        end
        nop_inputs();
        rst = 0;
        readData1 = 5; readData2 = 6; RegWrite = 1;
        step();
        nvec++; if (ALUresult !== 32'd11) begin nerr++; $display("FAIL reset_first_instr got %0d want 11", ALUresult); end
    endtask

    task automatic test_add_imm();
        nop_inputs();
        readData1 = 2; immediate = 15; ALUsrc = 1; ALUop = 3'b000; destinationReg = 0;
        RT = 12; RD = 3; readData2 = 32'd99; MEM_Write = 1;
        step();
        nvec++; if (ALUresult !== 32'd17) begin nerr++; $display("FAIL addi_result got %0d want 17", ALUresult); end
        nvec++; if (writeReg !== 5'd12) begin nerr++; $display("FAIL addi_writeReg got %0d want 12", writeReg); end
        nvec++; if (zero !== 1'b0) begin nerr++; $display("FAIL addi_zero got %b want 0", zero); end
        nvec++; if (writeData !== 32'd99) begin nerr++; $display("FAIL addi_writeData got %0d want 99", writeData); end
        nvec++; if ({MEM_Write_out, RegWrite_out} !== 2'b10) begin
            nerr++; $display("FAIL addi_ctrl got %b want 10", {MEM_Write_out, RegWrite_out}); end
    endtask

    typedef struct {
        logic [31:0] a, b, imm;
        logic        src;
        logic [2:0]  op;
        logic [5:0]  fn;
        logic [31:0] exp;
    } vec_t;

    task automatic test_alu_ops();
        vec_t t[14];
        t[0]  = '{32'd5,        32'd7,        32'd0,      1'b0, 3'b001, 6'd0,      32'hFFFF_FFFE};
        t[1]  = '{32'hF0F0_FFFF, 32'h0FF0_00FF, 32'd0,    1'b0, 3'b011, 6'd0,      32'h00F0_00FF};
        t[2]  = '{32'hF000_0000, 32'h0000_000F, 32'd0,    1'b0, 3'b100, 6'd0,      32'hF000_000F};
        t[3]  = '{32'hFFFF_FFFF, 32'd1,        32'd0,      1'b0, 3'b101, 6'd0,      32'd1};
        t[4]  = '{32'd0,        32'd77,       32'h0000_1234, 1'b1, 3'b110, 6'd0,   32'h1234_0000};
        t[5]  = '{32'd5,        32'd6,        32'd0,      1'b0, 3'b111, 6'd0,      32'd0};
        t[6]  = '{32'hFF00_FF00, 32'h0FF0_0FF0, 32'd0,    1'b0, 3'b010, 6'b100110, 32'hF0F0_F0F0};
        t[7]  = '{32'hFF00_0000, 32'h00FF_0000, 32'd0,    1'b0, 3'b010, 6'b100111, 32'h0000_FFFF};
        t[8]  = '{32'h1234,     32'h1234,     32'd0,      1'b0, 3'b010, 6'b100010, 32'd0};
        t[9]  = '{32'd1,        32'h8000_0000, 32'd0,     1'b0, 3'b010, 6'b101010, 32'd0};
        t[10] = '{32'hFFFF_FFFF, 32'd2,       32'd0,      1'b0, 3'b010, 6'b100000, 32'd1};
        t[11] = '{32'd3,        32'd4,        32'd0,      1'b0, 3'b010, 6'b000000, 32'd0};
        t[12] = '{32'hC,        32'hA,        32'd0,      1'b0, 3'b010, 6'b100100, 32'h8};
        t[13] = '{32'hC,        32'hA,        32'd0,      1'b0, 3'b010, 6'b100101, 32'hE};
        for (int i = 0; i < 14; i++) begin
            nop_inputs();
            readData1 = t[i].a; readData2 = t[i].b; immediate = t[i].imm; ALUsrc = t[i].src;
            ALUop = t[i].op; Function = t[i].fn; destinationReg = 1; RD = 5'(i + 1); RT = 5'd31;
            step();
            nvec++;
            if (ALUresult !== t[i].exp || zero !== (t[i].exp == 0) || writeReg !== 5'(i + 1) || writeData !== t[i].b) begin
                nerr++;
                $display("FAIL alu_vec%0d got res=%h z=%b wr=%0d wd=%h want res=%h z=%b wr=%0d wd=%h",
                    i, ALUresult, zero, writeReg, writeData, t[i].exp, t[i].exp == 0, i + 1, t[i].b);
            end
        end
    endtask

    task automatic test_branch();
        nop_inputs();
        readData1 = 10; readData2 = 10; branch = 1; nextPC = 3; immediate = 4; ALUop = 3'b001;
        step();
        nvec++; if (branchTaken !== 1'b1) begin nerr++; $display("FAIL beq_taken got %b want 1", branchTaken); end
        nvec++; if (branchTarget !== 32'd19) begin nerr++; $display("FAIL beq_target got %0d want 19", branchTarget); end
        nvec++; if (zero !== 1'b1) begin nerr++; $display("FAIL beq_zero got %b want 1", zero); end
        readData2 = 11;
        step();
        nvec++; if (branchTaken !== 1'b0) begin nerr++; $display("FAIL beq_not_taken got %b want 0", branchTaken); end
        nvec++; if (branchTarget !== 32'd19) begin nerr++; $display("FAIL beq_nt_target got %0d want 19", branchTarget); end
    endtask

    task automatic test_back_to_back();
        nop_inputs();
        readData1 = 100; readData2 = 1; ALUop = 3'b000;
        step();
        nvec++; if (ALUresult !== 32'd101) begin nerr++; $display("FAIL b2b_0 got %0d want 101", ALUresult); end
        ALUop = 3'b001;
        step();
        nvec++; if (ALUresult !== 32'd99) begin nerr++; $display("FAIL b2b_1 got %0d want 99", ALUresult); end
        ALUop = 3'b100; readData2 = 32'h0000_0F00;
        step();
        nvec++; if (ALUresult !== 32'h0000_0F64) begin nerr++; $display("FAIL b2b_2 got %h want 00000f64", ALUresult); end
    endtask

    task automatic test_freeze();
        nop_inputs();
        readData1 = 1; readData2 = 1; RegWrite = 1;
        step();
        hit = 0; readData1 = 3; readData2 = 3; RegWrite = 0;
        for (int i = 0; i < 3; i++) begin
            step();
            nvec++; if (ALUresult !== 32'd2 || RegWrite_out !== 1'b1) begin
                nerr++; $display("FAIL freeze_hold%0d got %0d/%b want 2/1", i, ALUresult, RegWrite_out); end
        end
        hit = 1;
        step();
        nvec++; if (ALUresult !== 32'd6) begin nerr++; $display("FAIL freeze_release got %0d want 6", ALUresult); end
    endtask

`ifdef EX_MULT_EN
    task automatic test_mult();
        set_mult(32'd23, 32'd10);
        #1;
        for (int i = 0; i < 32; i++) begin
            if (i > 0) step();
            nvec++; if (stall !== 1'b1) begin nerr++; $display("FAIL mult_stall_c%0d got %b want 1", i, stall); end
            if (i > 0) begin
                nvec++; if (ALUresult !== 0 || RegWrite_out !== 0 || writeReg !== 0) begin
                    nerr++; $display("FAIL mult_bubble_c%0d got %h/%b/%0d want 0/0/0", i, ALUresult, RegWrite_out, writeReg); end
            end
        end
        step();
        nvec++; if (stall !== 1'b0) begin nerr++; $display("FAIL mult_stall_end got %b want 0", stall); end
        step();
        nop_inputs();
        nvec++; if (ALUresult !== 32'd230 || RegWrite_out !== 1'b1 || writeReg !== 5'd7) begin
            nerr++; $display("FAIL mult_result got %0d/%b/%0d want 230/1/7", ALUresult, RegWrite_out, writeReg); end
        #1;
        nvec++; if (stall !== 1'b0) begin nerr++; $display("FAIL mult_after_stall got %b want 0", stall); end
    endtask

    task automatic test_freeze_mult();
        // 0x10000 * 0x10003 = 0x1_0003_0000 -> low word 0x0003_0000
        set_mult(32'h0001_0000, 32'h0001_0003);
        for (int i = 0; i < 11; i++) step();
        hit = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            nvec++; if (stall !== 1'b1 || ALUresult !== 0) begin
                nerr++; $display("FAIL fmult_hold%0d got %b/%h want 1/0", i, stall, ALUresult); end
        end
        hit = 1;
        for (int i = 0; i < 20; i++) step();
        #1;
        nvec++; if (stall !== 1'b1) begin nerr++; $display("FAIL fmult_count30 got %b want 1", stall); end
        step();
        nvec++; if (stall !== 1'b0 || ALUresult !== 0) begin
            nerr++; $display("FAIL fmult_count31 got %b/%h want 0/0", stall, ALUresult); end
        step();
        nop_inputs();
        nvec++; if (ALUresult !== 32'h0003_0000) begin nerr++; $display("FAIL fmult_result got %h want 00030000", ALUresult); end
    endtask

    task automatic test_reset_mult();
        set_mult(32'd23, 32'd10);
        for (int i = 0; i < 21; i++) step();
        rst = 1; nop_inputs();
        #1;
        nvec++; if (stall !== 1'b0) begin nerr++; $display("FAIL rmult_stall_in_rst got %b want 0", stall); end
        step();
        rst = 0;
        nvec++; if (ALUresult !== 0 || RegWrite_out !== 0) begin
            nerr++; $display("FAIL rmult_outputs got %h/%b want 0/0", ALUresult, RegWrite_out); end
        for (int i = 0; i < 15; i++) begin
            step();
            nvec++; if (stall !== 1'b0 || ALUresult !== 0 || RegWrite_out !== 0) begin
                nerr++; $display("FAIL rmult_late%0d got %b/%h/%b want 0/0/0", i, stall, ALUresult, RegWrite_out); end
        end
    endtask
`else
    task automatic test_mult();
        set_mult(32'd23, 32'd10);
        #1;
        nvec++; if (stall !== 1'b0) begin nerr++; $display("FAIL nomult_stall got %b want 0", stall); end
        step();
        nop_inputs();
        nvec++; if (ALUresult !== 0 || zero !== 1'b1 || RegWrite_out !== 1'b1 || writeReg !== 5'd7) begin
            nerr++; $display("FAIL nomult_result got %h/%b/%b/%0d want 0/1/1/7", ALUresult, zero, RegWrite_out, writeReg); end
    endtask
`endif

    initial begin
        nop_inputs();
        rst = 1; hit = 1;
        test_reset();
        test_add_imm();
        test_alu_ops();
        test_branch();
        test_back_to_back();
        test_freeze();
        test_mult();
`ifdef EX_MULT_EN
        test_freeze_mult();
        test_reset_mult();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
